// File: rtl/p_risc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : p_risc_pkg
// Description : Shared definitions for the P_Risc integer register file:
//               default data width, register address width, the x0 constant,
//               the clear-sequencer state encoding and an address range helper.
// Revision    : 1.0 - initial release
// ============================================================================
package p_risc_pkg;

  localparam int XLEN_DEF = 32;
  localparam int REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] X0 = '0;

  typedef enum logic [1:0] {
    CLR_IDLE = 2'd0,
    CLR_RUN  = 2'd1,
    CLR_DONE = 2'd2
  } clr_state_t;

  // True when the address names a real, writable register (not x0, below nregs).
  function automatic logic reg_addr_ok(input logic [REG_ADDR_W-1:0] a,
                                       input int unsigned nregs);
    return (a != X0) && (32'(a) < nregs);
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_clr_fsm.sv
`default_nettype none
// ============================================================================
// Module      : regfile_clr_fsm
// Description : Clear sequencer. On clr_req in IDLE it walks registers
//               1..NREGS-1 (one per cycle), then pulses clr_done for a cycle.
// Ports       : clk, rst_n   clock / async active-low reset
//               clr_req      start request, sampled only in IDLE
//               clr_busy     high in RUN and DONE
//               clr_done     one-cycle pulse after the last register
//               clr_en       clear strobe for register clr_addr this cycle
//               clr_addr     register being cleared
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_clr_fsm
  import p_risc_pkg::*;
#(
  parameter  int NREGS = 32,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_req,
  output logic          clr_busy,
  output logic          clr_done,
  output logic          clr_en,
  output logic [AW-1:0] clr_addr
);

  localparam logic [AW-1:0] LAST = AW'(NREGS - 1);

  clr_state_t    state, state_nxt;
  logic [AW-1:0] cnt;

  // State register; the counter restarts at 1 whenever not sweeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= CLR_IDLE;
      cnt   <= AW'(1);
    end else begin
      state <= state_nxt;
      cnt   <= (state == CLR_RUN) ? cnt + AW'(1) : AW'(1);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      CLR_IDLE: if (clr_req) state_nxt = CLR_RUN;
      CLR_RUN:  if (cnt == LAST) state_nxt = CLR_DONE;
      CLR_DONE: state_nxt = CLR_IDLE;
      default:  state_nxt = CLR_IDLE;
    endcase
  end

  always_comb begin
    clr_busy = (state != CLR_IDLE);
    clr_done = (state == CLR_DONE);
    clr_en   = (state == CLR_RUN);
    clr_addr = cnt;
  end

endmodule
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module      : regfile_sb
// Description : Integer register file with NRD combinational read ports, one
//               write port, x0 hard-wired to zero, a per-register pending
//               scoreboard and a one-register-per-cycle clear sequencer.
// Ports       : clk, rst_n          clock / async active-low reset
//               ra  [NRD*5]         read addresses, port i at [i*5+:5]
//               rd  [NRD*XLEN]      read data, port i at [i*XLEN+:XLEN]
//               rbusy [NRD]         port i's register has a pending write
//               we, wa, wd          write port
//               sb_set, sb_addr     mark a register pending
//               clr_req             start clear sequence
//               clr_busy, clr_done  clear sequence status
// Config      : REGFILE_BYPASS_EN - forward an accepted write to same-cycle
//               reads (and its scoreboard effect to rbusy).
// Revision    : 1.0 - initial release
// ============================================================================
module regfile_sb
  import p_risc_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NRD*5-1:0]      ra,
  output logic [NRD*XLEN-1:0]   rd,
  output logic [NRD-1:0]        rbusy,
  input  logic                  we,
  input  logic [4:0]            wa,
  input  logic [XLEN-1:0]       wd,
  input  logic                  sb_set,
  input  logic [4:0]            sb_addr,
  input  logic                  clr_req,
  output logic                  clr_busy,
  output logic                  clr_done
);

  logic [XLEN-1:0] regs [NREGS];
  logic [NREGS-1:0] sb;

  logic          busy;
  logic          clr_en;
  logic [AW-1:0] clr_addr;
  logic          wr_ok;
  logic          sb_ok;

  regfile_clr_fsm #(.NREGS(NREGS)) u_clr_fsm (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_req  (clr_req),
    .clr_busy (busy),
    .clr_done (clr_done),
    .clr_en   (clr_en),
    .clr_addr (clr_addr)
  );

  assign clr_busy = busy;

  // Writes and scoreboard sets are only honoured while the sequencer is idle.
  assign wr_ok = we     && reg_addr_ok(wa, NREGS)      && !busy;
  assign sb_ok = sb_set && reg_addr_ok(sb_addr, NREGS) && !busy;

  // x0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < NREGS; r++) regs[r] <= '0;
    end else if (clr_en) begin
      regs[clr_addr] <= '0;
    end else if (wr_ok) begin
      regs[wa[AW-1:0]] <= wd;
    end
  end

  // Later assignments win: a same-cycle set overrides the write's clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb <= '0;
    end else begin
      if (clr_en) sb[clr_addr] <= 1'b0;
      if (wr_ok)  sb[wa[AW-1:0]] <= 1'b0;
      if (sb_ok)  sb[sb_addr[AW-1:0]] <= 1'b1;
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [4:0]      a;
    logic            ok;
    logic [AW-1:0]   idx;
    logic [XLEN-1:0] d;
    logic            b;

    assign a   = ra[i*5 +: 5];
    assign ok  = reg_addr_ok(a, NREGS);
    assign idx = a[AW-1:0];

    always_comb begin
      d = ok ? regs[idx] : '0;
      b = ok & sb[idx];
`ifdef REGFILE_BYPASS_EN
      if (ok && wr_ok && (wa == a)) begin
        d = wd;
        b = sb_ok && (sb_addr == a);
      end
`endif
    end

    assign rd[i*XLEN +: XLEN] = d;
    assign rbusy[i]           = b;
  end

endmodule
`default_nettype wire
